fft_input_buffer: RTL
=====================

Name: fft_input_buffer

Overview:
- Collects a serial stream of real time-domain samples into one 8-sample frame.
- Presents the frame in parallel as x0..x7 to the 8-point FFT core. It is the input-side counterpart of the FFT result serializer.
- Double-buffered: a fill bank takes new samples while a hold bank keeps the previous frame stable until the FFT side acknowledges it.
- Valid/ready on the sample side; valid/ack on the frame side.

Parameters:
- WIDTH, 16: sample and frame-word width in bits (two's complement, passed through unmodified).

Ports:
- fastclk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- sample_in  input  WIDTH  incoming time-domain sample.
- sample_valid  input  1  sample_in is valid this cycle.
- sample_ready  output  1  block accepts a sample this cycle. A transfer occurs when sample_valid and sample_ready are both high at a rising edge.
- x0..x7  output  WIDTH each  hold-bank frame. x0 is the oldest sample and x7 the newest.
- frame_valid  output  1  x0..x7 hold an unconsumed frame.
- frame_ack  input  1  FFT side consumes the frame at this edge.
- fill_count  output  4  samples currently in the fill bank, 0..8.
- overrun  output  1  sticky: a sample was offered while sample_ready was low.

Behaviour:
- Reset (rst high at an edge):
  - Clears the fill bank, x0..x7 (to 0), frame_valid, fill_count, overrun and the write index.
  - sample_ready is 0 while rst is high.
  - A partial or held frame is discarded; no frame_valid pulse follows reset.
- sample_ready = !rst && (fill_count != 8). It is combinational from registered state.
- Accept:
  - On a transfer, sample_in is written to fill[wr_idx].
  - wr_idx increments, and fill_count increments.
  - wr_idx runs 0..7; after slot 7 is written the bank is full (fill_count = 8).
- Fill bank states:
  - FILLING (fill_count < 8): accepts samples.
  - FULL (fill_count = 8): sample_ready is 0.
  - FULL -> FILLING on the transfer edge, where wr_idx and fill_count return to 0.
- Transfer fill -> hold:
  - Occurs at an edge where the fill bank is FULL and the hold bank is free.
  - The hold bank is free when frame_valid == 0, or when frame_valid == 1 and frame_ack == 1 at that same edge (ack and reload coincide, so frame_valid stays 1 with the new data).
  - On the transfer edge: x0..x7 <= fill[0..7] and frame_valid <= 1.
- Latency: the 8th sample accepted at edge N gives x0..x7 and frame_valid updated at edge N+1 when the hold bank is free. Sample_ready is 0 for exactly one cycle in that case.
- Throughput: best case is 8 samples per 9 cycles.
- Ack handling:
  - frame_ack with frame_valid == 1 and no pending full fill bank: frame_valid <= 0, and x0..x7 keep their values.
  - frame_ack while frame_valid == 0 is ignored.
- Stall: if the fill bank is FULL and the hold bank is occupied without ack, the block waits. sample_ready stays 0, and x0..x7 and frame_valid hold steady.
- Overrun:
  - sample_valid == 1 while sample_ready == 0 (rst low) sets overrun to 1.
  - The offered sample is dropped; fill and hold banks are unaffected.
  - overrun clears only on rst.
- Simultaneous events:
  - A transfer into the fill bank cannot coincide with a fill->hold transfer (ready is low when full).
  - Ack plus reload at the same edge is defined under "Transfer fill -> hold".
- x0..x7 change only on a fill->hold transfer or on reset.

Test Plan:
- Reset, then feed samples 1..8 with sample_valid held high -> sample_ready drops for 1 cycle after the 8th; next edge x0=1 .. x7=8, frame_valid=1, fill_count=0.
- With frame 1..8 held (no ack), feed 9..16 then offer 17 -> fill_count=8 and sample_ready=0; x0..x7 stay 1..8; offering 17 sets overrun=1 and 17 is never stored. Pulse frame_ack -> at that edge x0..x7=9..16, frame_valid remains 1.
- Frame valid, assert frame_ack alone with fill_count=3 -> frame_valid=0 next edge, x0..x7 unchanged, fill continues from 4th slot.
- Pulse frame_ack while frame_valid=0 -> no state change.
- Feed samples 0x8000, 0x7FFF, 0xFFFF, 0x0001, 0, 0, 0, 0 -> x0..x7 bit-exact, no sign manipulation.
- Feed 5 samples, assert rst one cycle -> fill_count=0, frame_valid=0, overrun=0; then 8 new samples yield a frame of only the new samples.

Source files
------------

// File: rtl/fft_input_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : fft_input_buffer
//  Description : Gathers a serial sample stream into 8-sample frames and
//                presents each frame in parallel (x0 oldest .. x7 newest) to
//                an 8-point FFT core. Double-buffered: the fill bank collects
//                new samples while the hold bank keeps the last frame stable
//                until the FFT side acknowledges it.
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_input_buffer #(
   parameter int WIDTH = 16
) (
   input  logic             fastclk,
   input  logic             rst,
   input  logic [WIDTH-1:0] sample_in,
   input  logic             sample_valid,
   output logic             sample_ready,
   output logic [WIDTH-1:0] x0,
   output logic [WIDTH-1:0] x1,
   output logic [WIDTH-1:0] x2,
   output logic [WIDTH-1:0] x3,
   output logic [WIDTH-1:0] x4,
   output logic [WIDTH-1:0] x5,
   output logic [WIDTH-1:0] x6,
   output logic [WIDTH-1:0] x7,
   output logic             frame_valid,
   input  logic             frame_ack,
   output logic [3:0]       fill_count,
   output logic             overrun
);

   localparam logic [3:0] c_FULL_COUNT = 4'd8;

   logic [WIDTH-1:0] r_fill [0:7];
   logic [WIDTH-1:0] r_hold [0:7];
   logic [2:0]       r_wr_idx;
   logic [3:0]       r_fill_count;
   logic             r_frame_valid;
   logic             r_overrun;

   logic w_full;
   logic w_hold_free;
   logic w_reload;
   logic w_accept;
   logic w_ready;

   // Handshake decode from registered state; ready drops while the fill
   // bank is full, so a sample write can never coincide with a reload.
   always_comb begin
      w_full      = (r_fill_count == c_FULL_COUNT);
      w_hold_free = !r_frame_valid || frame_ack;
      w_reload    = w_full && w_hold_free;
      w_ready     = !rst && !w_full;
      w_accept    = sample_valid && w_ready;
   end

   // Fill bank: write accepted samples in arrival order, restart on reload.
   always_ff @(posedge fastclk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            r_fill[i] <= '0;
         end
         r_wr_idx     <= 3'd0;
         r_fill_count <= 4'd0;
      end else if (w_reload) begin
         r_wr_idx     <= 3'd0;
         r_fill_count <= 4'd0;
      end else if (w_accept) begin
         r_fill[r_wr_idx] <= sample_in;
         r_wr_idx         <= r_wr_idx + 3'd1;
         r_fill_count     <= r_fill_count + 4'd1;
      end
   end

   // Hold bank: load a full frame when free; a lone ack only clears valid.
   always_ff @(posedge fastclk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            r_hold[i] <= '0;
         end
         r_frame_valid <= 1'b0;
      end else if (w_reload) begin
         for (int i = 0; i < 8; i++) begin
            r_hold[i] <= r_fill[i];
         end
         r_frame_valid <= 1'b1;
      end else if (frame_ack && r_frame_valid) begin
         r_frame_valid <= 1'b0;
      end
   end

   // Sticky overrun: a sample offered while not ready is dropped and flagged.
   always_ff @(posedge fastclk) begin
      if (rst) begin
         r_overrun <= 1'b0;
      end else if (sample_valid && !w_ready) begin
         r_overrun <= 1'b1;
      end
   end

   assign sample_ready = w_ready;
   assign frame_valid  = r_frame_valid;
   assign fill_count   = r_fill_count;
   assign overrun      = r_overrun;
   assign x0 = r_hold[0];
   assign x1 = r_hold[1];
   assign x2 = r_hold[2];
   assign x3 = r_hold[3];
   assign x4 = r_hold[4];
   assign x5 = r_hold[5];
   assign x6 = r_hold[6];
   assign x7 = r_hold[7];

endmodule
`default_nettype wire
